decoder_nto2n_seq: RTL and testbench

//   Registered, parametrised N-to-2^N one-hot decoder with enable and three run-time modes:

---
 rtl/decoder_pkg.sv | 27 ++
 rtl/decoder_core.sv | 18 +
 rtl/decoder_nto2n_seq.sv | 147 ++++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the sequential N-to-2^N decoder: run-time mode
// codes, PULSE FSM state encoding and a width-generic one-hot helper.
package decoder_pkg;

  // Run-time mode codes as driven on the mode port.
  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  // Widest select the helper supports; callers size the result down.
  localparam int MAX_N    = 8;
  localparam int MAX_OUTS = 2 ** MAX_N;

  // PULSE strobe state.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

  // One-hot of idx within a 2**n wide field; indices outside that field give all zeros.
  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_N-1:0] idx, input int n);
    onehot = '0;
    if (int'(idx) < (1 << n)) onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N one-hot decoder with enable; all outputs low when disabled.
module decoder_core
  import decoder_pkg::*;
#(
  parameter  int N    = 2,
  localparam int OUTS = 2 ** N
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [OUTS-1:0] dec
);

  // Decode the select into a single active line when enabled.
  always_comb begin
    dec = en ? OUTS'(onehot(MAX_N'(sel), N)) : '0;
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with DIRECT, PULSE (handshaked strobe)
// and SCAN (auto-rotating select) modes, plus optional active-low outputs.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter  int N          = 2,
  parameter  int PULSE_LEN  = 1,
  parameter  int SCAN_DIV   = 4,
  parameter  int ACTIVE_LOW = 0,
  localparam int OUTS       = 2 ** N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    in,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [OUTS-1:0] out,
  output logic [N-1:0]    scan_idx,
  output logic            busy
);

  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  pulse_state_e     state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     pidx_q, pidx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [N-1:0]     sidx_d;
  logic             live_q, live_d;
  logic             busy_d;
  logic [N-1:0]     sel;
  logic             dec_en;
  logic [OUTS-1:0]  dec;
  logic             accept;

  // A request is only taken once the PULSE mode has settled (mode_q matches),
  // so a request made during the mode-change cycle is never silently dropped.
  assign in_ready = !rst && en && (mode == MODE_PULSE) && (mode == mode_q)
                    && (state_q == ST_IDLE || cnt_q == '0);
  assign accept   = in_valid && in_ready;

  decoder_core #(.N(N)) u_core (
    .sel (sel),
    .en  (dec_en),
    .dec (dec)
  );

  // Next-state, decoder select and strobe control for all modes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    pidx_d  = pidx_q;
    div_d   = div_q;
    sidx_d  = scan_idx;
    live_d  = live_q;
    busy_d  = 1'b0;
    sel     = in;
    dec_en  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      live_d  = 1'b0;
    end else if (mode != mode_q) begin
      // One settling cycle on any mode change: outputs idle, SCAN restarts at index 0.
      state_d = ST_IDLE;
      cnt_d   = '0;
      div_d   = '0;
      sidx_d  = '0;
      live_d  = 1'b0;
    end else begin
      case (mode)
        MODE_DIRECT: begin
          dec_en  = 1'b1;
          state_d = ST_IDLE;
        end
        MODE_PULSE: begin
          if (accept) begin
            dec_en  = 1'b1;
            pidx_d  = in;
            cnt_d   = CNT_W'(PULSE_LEN - 1);
            state_d = ST_ACTIVE;
            busy_d  = 1'b1;
          end else if (state_q == ST_ACTIVE && cnt_q != '0) begin
            sel     = pidx_q;
            dec_en  = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        MODE_SCAN: begin
          dec_en = 1'b1;
          if (!live_q) begin
            // First visible cycle: show the current index without advancing the divider,
            // so index 0 stays up for a full SCAN_DIV cycles after entry.
            live_d = 1'b1;
            sel    = scan_idx;
          end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d  = '0;
            sidx_d = scan_idx + N'(1);
            sel    = sidx_d;
          end else begin
            div_d  = div_q + DIV_W'(1);
            sel    = scan_idx;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; synchronous reset dominates everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    mode_q <= mode;
    if (rst) begin
      out      <= (ACTIVE_LOW != 0) ? '1 : '0;
      state_q  <= ST_IDLE;
      // Reset as OFF so the first active mode always gets a clean entry cycle.
      mode_q   <= MODE_OFF;
      cnt_q    <= '0;
      pidx_q   <= '0;
      div_q    <= '0;
      scan_idx <= '0;
      live_q   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      out      <= (ACTIVE_LOW != 0) ? ~dec : dec;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pidx_q   <= pidx_d;
      div_q    <= div_d;
      scan_idx <= sidx_d;
      live_q   <= live_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed self-checking bench for decoder_nto2n_seq: reset, DIRECT, PULSE
// handshake, reset and mode change mid-pulse, SCAN rotation and ACTIVE_LOW.
module tb_decoder_nto2n_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] in;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out;
  logic [1:0] scan_idx;
  logic       busy;

  logic [1:0] mode_b;
  logic [2:0] in_b;
  logic       in_valid_b;
  logic       in_ready_b;
  logic [7:0] out_b;
  logic [2:0] scan_idx_b;
  logic       busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(2), .PULSE_LEN(2), .SCAN_DIV(3), .ACTIVE_LOW(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .in       (in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .scan_idx (scan_idx),
    .busy     (busy)
  );

  decoder_nto2n_seq #(.N(3), .ACTIVE_LOW(1)) dut_al (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode_b),
    .in       (in_b),
    .in_valid (in_valid_b),
    .in_ready (in_ready_b),
    .out      (out_b),
    .scan_idx (scan_idx_b),
    .busy     (busy_b)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_idx;

    // Reset with arbitrary inputs applied.
    rst = 1'b1; en = 1'b1; mode = 2'b01; in = 2'd3; in_valid = 1'b1;
    mode_b = 2'b00; in_b = 3'd5; in_valid_b = 1'b0;
    step(); step();
    check("rst_out", out, 4'b0000);
    check("rst_scan_idx", scan_idx, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_al", out_b, 8'hFF);

    // DIRECT: one settling cycle after the mode change, then decode.
    rst = 1'b0; mode = 2'b00; in = 2'd2; in_valid = 1'b0;
    step();
    check("direct_change_cycle", out, 4'b0000);
    step();
    check("direct_in2", out, 4'b0100);
    check("direct_al_in5", out_b, 8'b1101_1111);
    en = 1'b0;
    step();
    check("direct_en0", out, 4'b0000);
    check("direct_al_en0", out_b, 8'hFF);
    en = 1'b1; in = 2'd0;
    step();
    check("direct_in0", out, 4'b0001);
    in = 2'd3;
    step();
    check("direct_in3", out, 4'b1000);

    // PULSE back-to-back: in=3 then in=1.
    mode = 2'b01; in = 2'd3; in_valid = 1'b1;
    step();
    check("pulse_change_cycle", out, 4'b0000);
    #1 check("pulse_ready_idle", in_ready, 1'b1);
    step();
    check("pulse_a_c1", out, 4'b1000);
    check("pulse_a_busy", busy, 1'b1);
    check("pulse_a_ready_c1", in_ready, 1'b0);
    step();
    check("pulse_a_c2", out, 4'b1000);
    in = 2'd1;
    #1 check("pulse_a_ready_c2", in_ready, 1'b1);
    step();
    check("pulse_b_c1", out, 4'b0010);
    check("pulse_b_ready_c1", in_ready, 1'b0);
    step();
    check("pulse_b_c2", out, 4'b0010);
    check("pulse_b_ready_c2", in_ready, 1'b1);
    in_valid = 1'b0;
    step();
    check("pulse_end", out, 4'b0000);
    check("pulse_end_busy", busy, 1'b0);

    // Reset in the first cycle of a strobe.
    in = 2'd2; in_valid = 1'b1;
    step();
    check("pulse_c_c1", out, 4'b0100);
    rst = 1'b1; in_valid = 1'b0;
    step();
    check("pulse_rst_out", out, 4'b0000);
    check("pulse_rst_busy", busy, 1'b0);

    // Mode change in the first cycle of a strobe.
    rst = 1'b0;
    step();
    in = 2'd0; in_valid = 1'b1;
    step();
    check("pulse_d_c1", out, 4'b0001);
    check("pulse_d_busy", busy, 1'b1);
    in_valid = 1'b0; mode = 2'b10;
    step();
    check("pulse_modechg_out", out, 4'b0000);
    check("pulse_modechg_busy", busy, 1'b0);

    // SCAN: 13 cycles, each index held for 3, wrapping back to 0.
    for (int i = 0; i < 13; i++) begin
      step();
      exp_idx = 2'((i / 3) % 4);
      check($sformatf("scan_out_%0d", i), out, 4'b0001 << exp_idx);
      check($sformatf("scan_idx_%0d", i), scan_idx, exp_idx);
    end

    // Enable low blanks the output and holds the index; resuming shows it for a full period.
    en = 1'b0;
    step();
    check("scan_en0_out", out, 4'b0000);
    check("scan_en0_idx", scan_idx, 2'd0);
    en = 1'b1;
    step();
    check("scan_resume_c1", out, 4'b0001);
    step();
    check("scan_resume_c2", out, 4'b0001);
    step();
    check("scan_resume_c3", out, 4'b0001);
    step();
    check("scan_resume_adv", out, 4'b0010);
    check("scan_resume_idx", scan_idx, 2'd1);

    // OFF: outputs idle and no handshake.
    mode = 2'b11; in_valid = 1'b1;
    step();
    step();
    check("off_out", out, 4'b0000);
    check("off_in_ready", in_ready, 1'b0);
    check("off_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
